// File: rtl/iob_bus_arbiter_pkg.sv
// Shared definitions for the two-master native-bus arbiter.
//   - FSM state encoding (ST_IDLE / ST_BUSY)
//   - Master index constants (M_IBUS = CPU instruction bus, M_DBUS = CPU data bus)
//   - Default widths and helpers that size the packed request/response buses.
// Request bus layout  (MSB..LSB): {valid, address[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
// Response bus layout (MSB..LSB): {rdata[DATA_W], ready}
package iob_bus_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam logic M_IBUS = 1'b0;
  localparam logic M_DBUS = 1'b1;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Width of a packed request bus: valid + address + wdata + wstrb.
  function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Width of a packed response bus: rdata + ready.
  function automatic int unsigned resp_w(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_arb_sel2.sv
// Combinational two-way winner select for iob_bus_arbiter.
// Ports:
//   pend_i   [1:0]  pending-request flags, bit N = master N
//   last_i          index of the master served most recently
//   any_o           at least one master is pending
//   winner_o        index of the master to serve next (meaningful when any_o)
// Configuration macro: ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, master 0 always wins; last_i is ignored
//   undefined -> round-robin: on a tie the master not served last wins
module iob_arb_sel2
  import iob_bus_arbiter_pkg::*;
(
  input  logic [1:0] pend_i,
  input  logic       last_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o = |pend_i;

`ifdef ARB_FIXED_PRIO_EN
  // History is irrelevant with a fixed priority order.
  logic unused_last;
  assign unused_last = last_i;

  // Instruction fetch first; a busy data bus waits until ibus goes quiet.
  assign winner_o = pend_i[M_IBUS] ? M_IBUS : M_DBUS;
`else
  always_comb begin
    if (&pend_i) begin
      // Tie: alternate away from whoever was served last.
      winner_o = ~last_i;
    end else begin
      winner_o = pend_i[M_DBUS] ? M_DBUS : M_IBUS;
    end
  end
`endif

endmodule

// File: rtl/iob_bus_arbiter.sv
// Two-master to one-slave native bus arbiter.
// Sits between the CPU (ibus = m0, dbus = m1) and the memory interconnect.
// Each master's single-cycle valid pulse is captured into a pending slot;
// the FSM then serves one pending request at a time on the slave bus and
// routes the slave's ready/rdata pulse back to the granted master only.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   m0_req / m0_resp    master 0 (ibus) request in / response out
//   m1_req / m1_resp    master 1 (dbus) request in / response out
//   s_req  / s_resp     slave request out / response in
//   grant               index of the master owning the slave (valid while busy)
//   busy                a slave transaction is outstanding
// Configuration macro: ARB_FIXED_PRIO_EN (fixed priority, m0 wins every tie;
//   the round-robin history register is not built). Default: round-robin.
// Timing: valid at cycle k -> captured at end of k -> winner selected in k+1
//   -> slave valid pulse in k+2. The slave response is forwarded with no
//   added latency in the cycle it arrives.
module iob_bus_arbiter
  import iob_bus_arbiter_pkg::*;
#(
  parameter  int unsigned ADDR_W = DEF_ADDR_W,
  parameter  int unsigned DATA_W = DEF_DATA_W,
  localparam int unsigned REQ_W  = req_w(ADDR_W, DATA_W),
  localparam int unsigned RESP_W = resp_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ_W-1:0]  m0_req,
  output logic [RESP_W-1:0] m0_resp,
  input  logic [REQ_W-1:0]  m1_req,
  output logic [RESP_W-1:0] m1_resp,
  output logic [REQ_W-1:0]  s_req,
  input  logic [RESP_W-1:0] s_resp,
  output logic              grant,
  output logic              busy
);

  // Everything below the valid bit is payload that is stored and replayed
  // untouched: {address, wdata, wstrb}.
  localparam int unsigned PAY_W   = REQ_W - 1;
  localparam int unsigned VLD_BIT = REQ_W - 1;
  localparam int unsigned RDY_BIT = 0;

  logic [1:0]       m_valid;
  logic [PAY_W-1:0] m_pay [2];
  logic             s_ready;

  assign m_valid[M_IBUS] = m0_req[VLD_BIT];
  assign m_valid[M_DBUS] = m1_req[VLD_BIT];
  assign m_pay[M_IBUS]   = m0_req[PAY_W-1:0];
  assign m_pay[M_DBUS]   = m1_req[PAY_W-1:0];
  assign s_ready         = s_resp[RDY_BIT];

  // Capture slots and FSM state.
  logic [1:0]       pend_q, pend_d;
  logic [PAY_W-1:0] pay_q [2];
  logic [PAY_W-1:0] pay_d [2];
  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             svld_q, svld_d;
  logic             last;

  logic [1:0]       cap;
  logic [1:0]       done;
  logic             sel_any;
  logic             sel_win;

  // ---------------------------------------------------------------------------
  // Capture: a valid pulse claims an empty slot. A slot is freed in the cycle
  // its slave ready returns, so the other master may capture in that same
  // cycle without interference.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      cap[n]    = m_valid[n] & ~pend_q[n];
      done[n]   = (state_q == ST_BUSY) & s_ready & (grant_q == 1'(n));
      pend_d[n] = (pend_q[n] & ~done[n]) | cap[n];
      pay_d[n]  = cap[n] ? m_pay[n] : pay_q[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      pay_q[0] <= '0;
      pay_q[1] <= '0;
    end else begin
      pend_q   <= pend_d;
      pay_q[0] <= pay_d[0];
      pay_q[1] <= pay_d[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection (round-robin or fixed priority, chosen at build time).
  // ---------------------------------------------------------------------------
  iob_arb_sel2 u_sel (
    .pend_i   (pend_q),
    .last_i   (last),
    .any_o    (sel_any),
    .winner_o (sel_win)
  );

  // ---------------------------------------------------------------------------
  // FSM: IDLE picks a winner and arms a one-cycle slave valid; BUSY holds the
  // payload on the slave bus until ready comes back.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= M_IBUS;
      svld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      svld_q  <= svld_d;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign last = M_DBUS;
`else
  logic last_q, last_d;

  // Reset value M_DBUS makes m0 win the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= M_DBUS;
    end else begin
      last_q <= last_d;
    end
  end

  assign last = last_q;

  always_comb begin
    last_d = last_q;
    if ((state_q == ST_BUSY) && s_ready) begin
      last_d = grant_q;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    svld_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          grant_d = sel_win;
          svld_d  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (s_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: slave bus is quiet outside BUSY; responses are gated so only the
  // granted master ever sees a non-zero response, and only on ready.
  // ---------------------------------------------------------------------------
  assign busy  = (state_q == ST_BUSY);
  assign grant = grant_q;
  assign s_req = busy ? {svld_q, pay_q[grant_q]} : '0;

  always_comb begin
    m0_resp = '0;
    m1_resp = '0;
    if (busy && s_ready) begin
      if (grant_q == M_DBUS) begin
        m1_resp = s_resp;
      end else begin
        m0_resp = s_resp;
      end
    end
  end

`ifndef SYNTHESIS
  // A master may not pulse valid again before its previous request completes.
  always_ff @(posedge clk) begin
    if (rst_n && m_valid[M_IBUS] && pend_q[M_IBUS]) begin
      $error("iob_bus_arbiter: m0 valid while its request is still pending");
    end
    if (rst_n && m_valid[M_DBUS] && pend_q[M_DBUS]) begin
      $error("iob_bus_arbiter: m1 valid while its request is still pending");
    end
  end
`endif

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Self-checking bench for iob_bus_arbiter: directed scenarios followed by a
// randomized run, all compared cycle by cycle against a transaction-level
// reference model of the arbitration rules.
module tb_iob_bus_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int PAY_W  = AW + DW + SW;
  localparam int REQ_W  = PAY_W + 1;
  localparam int RESP_W = DW + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REQ_W-1:0]  m0_req, m1_req, s_req;
  logic [RESP_W-1:0] m0_resp, m1_resp, s_resp;
  logic              grant, busy;

  always #5 clk = ~clk;

  iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0_req  (m0_req),
    .m0_resp (m0_resp),
    .m1_req  (m1_req),
    .m1_resp (m1_resp),
    .s_req   (s_req),
    .s_resp  (s_resp),
    .grant   (grant),
    .busy    (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each master owns at most one request slot; the slave is either free or
  // serving exactly one owner. A newly started transaction shows its valid
  // pulse only in its first cycle on the slave bus.
  bit               mp [2];
  logic [PAY_W-1:0] mpay [2];
  bit               mbusy, mfirst, mown, mlast;

  logic [PAY_W-1:0] hp0, hp1;   // payload each master is holding

  task automatic model_reset();
    mp[0] = 0; mp[1] = 0;
    mpay[0] = '0; mpay[1] = '0;
    mbusy = 0; mfirst = 0; mown = 0; mlast = 1;
  endtask

  function automatic bit pick(input bit p0, input bit p1);
`ifdef ARB_FIXED_PRIO_EN
    return p0 ? 1'b0 : 1'b1;
`else
    if (p0 && p1) return !mlast;
    return p1;
`endif
  endfunction

  function automatic logic [PAY_W-1:0] mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    return {a, d, s};
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input bit v0, input bit v1, input bit rdy, input logic [31:0] rd);
    logic [REQ_W-1:0]  e_sreq;
    logic [RESP_W-1:0] e_r0, e_r1;
    bit p0o, p1o;
    @(negedge clk);
    m0_req = {v0, hp0};
    m1_req = {v1, hp1};
    s_resp = {rd, rdy};
    #1;
    e_sreq = mbusy ? {mfirst, mpay[mown]} : '0;
    e_r0   = (mbusy && rdy && !mown) ? {rd, rdy} : '0;
    e_r1   = (mbusy && rdy &&  mown) ? {rd, rdy} : '0;
    chk_eq("s_req",   s_req,   e_sreq);
    chk_eq("m0_resp", m0_resp, e_r0);
    chk_eq("m1_resp", m1_resp, e_r1);
    chk_eq("busy",    busy,    mbusy);
    if (mbusy) chk_eq("grant", grant, mown);
    p0o = mp[0];
    p1o = mp[1];
    if (mbusy) begin
      mfirst = 0;
      if (rdy) begin
        mp[mown] = 0;
        mlast    = mown;
        mbusy    = 0;
      end
    end else if (p0o || p1o) begin
      mown   = pick(p0o, p1o);
      mbusy  = 1;
      mfirst = 1;
    end
    if (v0 && !p0o) begin mp[0] = 1; mpay[0] = hp0; end
    if (v1 && !p1o) begin mp[1] = 1; mpay[1] = hp1; end
  endtask

  initial begin
    bit o0, o1, v0, v1, rdy;
    int scnt;
    m0_req = '0; m1_req = '0;
    hp0 = '0; hp1 = '0;
    s_resp = {32'hFFFF_FFFF, 1'b1};
    model_reset();

    // Reset state, with a stray slave ready that must stay blocked.
    repeat (2) @(negedge clk);
    #1;
    chk_eq("rst_busy",  busy,    1'b0);
    chk_eq("rst_grant", grant,   1'b0);
    chk_eq("rst_sreq",  s_req,   '0);
    chk_eq("rst_m0",    m0_resp, '0);
    chk_eq("rst_m1",    m1_resp, '0);
    @(negedge clk);
    rst_n = 1'b1;
    s_resp = '0;

    // Single read from m0: slave valid at k+2, ready at k+4.
    hp0 = mk(32'h100, 32'h0, 4'h0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk_eq("rd_svalid", s_req[REQ_W-1], 1'b1);
    chk_eq("rd_addr",   s_req[PAY_W-1 -: AW], 32'h100);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'hDEADBEEF);
    chk_eq("rd_m0resp", m0_resp, {32'hDEADBEEF, 1'b1});

    // Write from m1: fields pass through unchanged, ready only to m1.
    hp1 = mk(32'h8000_0004, 32'h1234_5678, 4'b0011);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk_eq("wr_sreq", s_req, {1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011});
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0);
    chk_eq("wr_m1rdy", m1_resp[0], 1'b1);
    chk_eq("wr_m0",    m0_resp,    '0);

    // Tie after reset-history: m0 first, m1 right behind.
    hp0 = mk(32'h200, 32'h0, 4'h0);
    hp1 = mk(32'h300, 32'h0, 4'h0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk_eq("tie1_first", grant, 1'b0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h1111);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk_eq("tie1_second", grant, 1'b1);
    chk_eq("tie1_s_addr", s_req[PAY_W-1 -: AW], 32'h300);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h2222);

    // Lone m0 then another tie: round-robin now favours m1.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h3333);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
`ifdef ARB_FIXED_PRIO_EN
    chk_eq("tie2_first", grant, 1'b0);
`else
    chk_eq("tie2_first", grant, 1'b1);
`endif
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h4444);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h5555);

    // Overlap: m1 valid in the cycle m0's ready returns.
    hp0 = mk(32'h400, 32'h0, 4'h0);
    hp1 = mk(32'h500, 32'hA5A5_A5A5, 4'hF);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 1, 32'h6666);
    chk_eq("ovl_m0rdy", m0_resp[0], 1'b1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk_eq("ovl_grant", grant, 1'b1);
    cycle(0, 0, 1, 32'h7777);
    chk_eq("ovl_m1resp", m1_resp, {32'h7777, 1'b1});

    // Reset while m1 is in flight: everything clears at once, late ready dropped.
    hp1 = mk(32'h600, 32'h0, 4'h0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk);
    s_resp = {32'hCAFE_F00D, 1'b1};
    rst_n = 1'b0;
    #1;
    chk_eq("rstmid_busy", busy,    1'b0);
    chk_eq("rstmid_sreq", s_req,   '0);
    chk_eq("rstmid_m0",   m0_resp, '0);
    chk_eq("rstmid_m1",   m1_resp, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s_resp = '0;
    cycle(0, 0, 1, 32'hCAFE_F00D);
    chk_eq("rstmid_late", m1_resp, '0);

    // Randomized traffic: masters issue when free, slave answers 1..3 cycles late.
    o0 = 0; o1 = 0; scnt = 0;
    for (int i = 0; i < 3000; i++) begin
      v0 = !o0 && ($urandom_range(0, 2) == 0);
      v1 = !o1 && ($urandom_range(0, 2) == 0);
      if (v0) hp0 = {$urandom(), $urandom(), 4'($urandom())};
      if (v1) hp1 = {$urandom(), $urandom(), 4'($urandom())};
      rdy = (scnt == 1);
      if (scnt > 0) scnt--;
      cycle(v0, v1, rdy, $urandom());
      if (v0) o0 = 1;
      if (v1) o1 = 1;
      if (m0_resp[0]) o0 = 0;
      if (m1_resp[0]) o1 = 0;
      if (s_req[REQ_W-1]) scnt = $urandom_range(1, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
